gb_cpu_sequencer: RTL and testbench

M-cycle sequencer for the Game Boy CPU; consumes the per-instruction `schedule_t` produced by `gb_cpu_decoder` and plays it back one M-cycle at a time. Owns the instruction register, the 0xCB prefix state and the T-cycle phase. Drives the opcode and `cb_prefix` into the decoder and broadcasts the active M-cycle control word to the datapath. Sits between the memory interface and the decoder/datapath in the CPU core.

---
 rtl/gb_cpu_sequencer_pkg.sv | 48 ++++
 rtl/gb_cpu_sequencer_if.sv | 29 ++
 rtl/gb_cpu_tcycle_counter.sv | 27 ++
 rtl/gb_cpu_sequencer.sv | 149 ++++++++++++++
 tb/tb_gb_cpu_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_cpu_sequencer_pkg.sv
// gb_cpu_sequencer_pkg: shared types and constants for the M-cycle sequencer.
// Holds the per-M-cycle control word, the decoder schedule, the sequencer
// state encoding and the fixed FETCH / IDLE control words.
package gb_cpu_sequencer_pkg;

  localparam int DEF_T_PER_M = 4;
  localparam int DEF_MAX_M   = 6;

  typedef struct packed {
    logic       addr_pc;     // PC drives the address bus
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_inc;
    logic [3:0] alu_op;
    logic [2:0] reg_src;
    logic [2:0] reg_dst;
    logic       cond_check;  // branch point: abort when cond_met is low
    logic       halt;        // HALT opcode final cycle
  } control_t;

  typedef struct packed {
    logic [2:0]                 m_cycles;
    control_t [0:DEF_MAX_M-1]   cycle;
  } schedule_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

  localparam control_t FETCH_CTRL = '{
    addr_pc: 1'b1, mem_rd: 1'b1, mem_wr: 1'b0, pc_inc: 1'b1,
    alu_op: 4'd0, reg_src: 3'd0, reg_dst: 3'd0, cond_check: 1'b0, halt: 1'b0
  };

  localparam control_t IDLE_CTRL = '0;

  // Index of the final M-cycle; a zero or oversized count runs as one cycle.
  function automatic logic [2:0] last_m_idx(input logic [2:0] m_cycles,
                                            input logic [2:0] max_m);
    if (m_cycles == 3'd0 || m_cycles > max_m) begin
      return 3'd0;
    end
    return m_cycles - 3'd1;
  endfunction

endpackage

// File: rtl/gb_cpu_sequencer_if.sv
// gb_cpu_sequencer_if: decoder/memory/datapath-facing signals of the
// sequencer. master = sequencer side, slave = surrounding core.
interface gb_cpu_sequencer_if;
  import gb_cpu_sequencer_pkg::*;

  schedule_t  schedule;
  logic [7:0] mem_rdata;
  logic       cond_met;
  logic       irq_pending;

  logic [7:0] opcode;
  logic       cb_prefix;
  control_t   ctrl;
  logic [2:0] m_idx;
  logic [1:0] t_phase;
  logic       instr_done;
  logic       halted;

  modport master (
    input  schedule, mem_rdata, cond_met, irq_pending,
    output opcode, cb_prefix, ctrl, m_idx, t_phase, instr_done, halted
  );

  modport slave (
    output schedule, mem_rdata, cond_met, irq_pending,
    input  opcode, cb_prefix, ctrl, m_idx, t_phase, instr_done, halted
  );

endinterface

// File: rtl/gb_cpu_tcycle_counter.sv
// gb_cpu_tcycle_counter: wrapping T-cycle phase counter. m_edge is high on
// the last T-cycle of each M-cycle, the only clock where sequencer state moves.
module gb_cpu_tcycle_counter #(
  parameter int T_PER_M = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] t_phase,
  output logic       m_edge
);

  localparam logic [1:0] T_LAST = 2'(T_PER_M - 1);

  assign m_edge = (t_phase == T_LAST);

  // Phase advances every clock and wraps at the end of the M-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_phase <= 2'd0;
    end else if (m_edge) begin
      t_phase <= 2'd0;
    end else begin
      t_phase <= t_phase + 2'd1;
    end
  end

endmodule

// File: rtl/gb_cpu_sequencer.sv
// gb_cpu_sequencer: plays back the decoder schedule one M-cycle at a time,
// owns the instruction register, the 0xCB prefix flag and the T-cycle phase.
// Optional HALT support is built when GB_CPU_SEQUENCER_HALT_EN is defined;
// otherwise the halt bit is ignored and halted stays low.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | standalone opcode fetch (after reset, failed branch, wake)
// EXEC  | running schedule.cycle[m_idx]; last cycle overlaps next fetch
// HALT  | waiting for irq_pending, bus idle
module gb_cpu_sequencer
  import gb_cpu_sequencer_pkg::*;
#(
  parameter int T_PER_M = DEF_T_PER_M,
  parameter int MAX_M   = DEF_MAX_M
) (
  input  logic               clk,
  input  logic               reset,
  gb_cpu_sequencer_if.master bus
);

  localparam logic [2:0] MAX_M_W = 3'(MAX_M);

  seq_state_t state_q, state_d;
  logic [2:0] m_idx_q, m_idx_d;
  logic [7:0] opcode_q, opcode_d;
  logic       cb_q, cb_d;
  logic       cond_fail_q, cond_fail_d;

  logic [1:0] t_phase;
  logic       m_edge;
  logic [2:0] last_idx;
  control_t   sched_ctrl;
  control_t   ctrl_c;
  logic       done_c;
  logic       halted_c;

  gb_cpu_tcycle_counter #(
    .T_PER_M (T_PER_M)
  ) u_tcycle (
    .clk     (clk),
    .reset   (reset),
    .t_phase (t_phase),
    .m_edge  (m_edge)
  );

  assign last_idx   = last_m_idx(bus.schedule.m_cycles, MAX_M_W);
  assign sched_ctrl = bus.schedule.cycle[m_idx_q];

`ifndef GB_CPU_SEQUENCER_HALT_EN
  logic unused_irq;
  assign unused_irq = bus.irq_pending;
`endif

  // State register; everything below only changes value on M-edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      m_idx_q     <= 3'd0;
      opcode_q    <= 8'h00;
      cb_q        <= 1'b0;
      cond_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_idx_q     <= m_idx_d;
      opcode_q    <= opcode_d;
      cb_q        <= cb_d;
      cond_fail_q <= cond_fail_d;
    end
  end

  // Next-state, IR/prefix updates and the per-state control word.
  always_comb begin
    state_d     = state_q;
    m_idx_d     = m_idx_q;
    opcode_d    = opcode_q;
    cb_d        = cb_q;
    cond_fail_d = cond_fail_q;
    ctrl_c      = IDLE_CTRL;
    done_c      = 1'b0;
    halted_c    = 1'b0;

    case (state_q)
      FETCH: begin
        ctrl_c = FETCH_CTRL;
        if (m_edge) begin
          opcode_d    = bus.mem_rdata;
          m_idx_d     = 3'd0;
          cb_d        = 1'b0;
          // A fetch that follows an aborted branch is where that
          // instruction is reported complete.
          done_c      = cond_fail_q;
          cond_fail_d = 1'b0;
          state_d     = EXEC;
        end
      end

      EXEC: begin
        ctrl_c = sched_ctrl;
        if (m_edge) begin
          if (sched_ctrl.cond_check && !bus.cond_met) begin
            state_d     = FETCH;
            m_idx_d     = 3'd0;
            cond_fail_d = 1'b1;
          end else if (m_idx_q >= last_idx) begin
            done_c  = 1'b1;
            m_idx_d = 3'd0;
`ifdef GB_CPU_SEQUENCER_HALT_EN
            if (sched_ctrl.halt && !bus.irq_pending) begin
              state_d = HALT;
              cb_d    = 1'b0;
            end else begin
              opcode_d = bus.mem_rdata;
              cb_d     = !cb_q && (opcode_q == 8'hCB);
            end
`else
            opcode_d = bus.mem_rdata;
            cb_d     = !cb_q && (opcode_q == 8'hCB);
`endif
          end else begin
            m_idx_d = m_idx_q + 3'd1;
          end
        end
      end

`ifdef GB_CPU_SEQUENCER_HALT_EN
      HALT: begin
        halted_c = 1'b1;
        if (m_edge && bus.irq_pending) begin
          state_d = FETCH;
        end
      end
`endif

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign bus.opcode     = opcode_q;
  assign bus.cb_prefix  = cb_q;
  assign bus.ctrl       = ctrl_c;
  assign bus.m_idx      = m_idx_q;
  assign bus.t_phase    = t_phase;
  assign bus.instr_done = done_c;
  assign bus.halted     = halted_c;

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// tb_gb_cpu_sequencer: scenario bench for gb_cpu_sequencer. A small decoder
// stand-in drives the schedule; expected instruction completions are queued
// when a program is set up and popped whenever instr_done fires.
// Expectations follow GB_CPU_SEQUENCER_HALT_EN when it is defined.
module tb_gb_cpu_sequencer;
  import gb_cpu_sequencer_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] op;
    logic       cb;
  } done_t;

  logic  clk;
  logic  reset;
  int    cyc;
  int    errors = 0;
  int    checks = 0;
  done_t sb_q[$];

  gb_cpu_sequencer_if bus();

  gb_cpu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock number since the last reset clock (clock 0 shows reset values).
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic schedule_t tb_decode(input logic [7:0] op, input logic cb);
    schedule_t s;
    s = '0;
    if (cb) begin
      s.m_cycles = 3'd2;
    end else begin
      case (op)
        8'h11:   s.m_cycles = 3'd3;
        8'h20:   s.m_cycles = 3'd3;
        8'h08:   s.m_cycles = 3'd5;
        8'h07:   s.m_cycles = 3'd0;
        8'h17:   s.m_cycles = 3'd7;
        default: s.m_cycles = 3'd1;
      endcase
    end
    for (int i = 0; i < DEF_MAX_M; i++) begin
      s.cycle[i].mem_rd  = 1'b1;
      s.cycle[i].mem_wr  = cb;
      s.cycle[i].alu_op  = 4'(i + 1);
      s.cycle[i].reg_src = op[2:0];
      s.cycle[i].reg_dst = op[5:3];
    end
    if (!cb && op == 8'h20) s.cycle[1].cond_check = 1'b1;
    if (!cb && op == 8'h76) s.cycle[0].halt = 1'b1;
    return s;
  endfunction

  always_comb bus.schedule = tb_decode(bus.opcode, bus.cb_prefix);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset           = 1'b1;
    bus.mem_rdata   = 8'h00;
    bus.cond_met    = 1'b1;
    bus.irq_pending = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.t_phase !== 2'd0) begin errors++; $display("FAIL reset_t_phase got %0d want 0", bus.t_phase); end
    checks++; if (bus.m_idx !== 3'd0) begin errors++; $display("FAIL reset_m_idx got %0d want 0", bus.m_idx); end
    checks++; if (bus.opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode got %h want 00", bus.opcode); end
    checks++; if (bus.cb_prefix !== 1'b0) begin errors++; $display("FAIL reset_cb_prefix got %b want 0", bus.cb_prefix); end
    checks++; if (bus.instr_done !== 1'b0) begin errors++; $display("FAIL reset_instr_done got %b want 0", bus.instr_done); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    checks++; if (bus.ctrl !== FETCH_CTRL) begin errors++; $display("FAIL reset_ctrl got %h want %h", bus.ctrl, FETCH_CTRL); end
  endtask

  task automatic test_single_cycle();
    done_t e;
    do_reset();
    bus.mem_rdata = 8'h80;
    sb_q.push_back('{7, 8'h80, 1'b0});
    sb_q.push_back('{11, 8'h80, 1'b0});
    sb_q.push_back('{15, 8'h80, 1'b0});
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 3) begin checks++; if (bus.opcode !== 8'h00) begin errors++; $display("FAIL single_opcode_c3 got %h want 00", bus.opcode); end end
      if (c == 4) begin checks++; if (bus.opcode !== 8'h80) begin errors++; $display("FAIL single_opcode_c4 got %h want 80", bus.opcode); end end
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL single_done unexpected pulse at clock %0d", cyc); end
        else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || bus.opcode !== e.op || bus.cb_prefix !== e.cb) begin errors++;
            $display("FAIL single_done got clock %0d op %h cb %b want clock %0d op %h cb %b", cyc, bus.opcode, bus.cb_prefix, e.cyc, e.op, e.cb); end
        end
      end
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL single_missing_done pending %0d want 0", sb_q.size()); end
  endtask

  task automatic test_multi_cycle();
    done_t e;
    schedule_t exp;
    int idx;
    do_reset();
    bus.mem_rdata = 8'h11;
    exp = tb_decode(8'h11, 1'b0);
    sb_q.push_back('{15, 8'h11, 1'b0});
    sb_q.push_back('{19, 8'h00, 1'b0});
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 4) bus.mem_rdata = 8'h00;
      if (c >= 4 && c <= 15) begin
        idx = (c - 4) / 4;
        checks++;
        if (bus.m_idx !== 3'(idx) || bus.ctrl !== exp.cycle[idx]) begin errors++;
          $display("FAIL multi_step clock %0d got m_idx %0d ctrl %h want m_idx %0d ctrl %h", c, bus.m_idx, bus.ctrl, idx, exp.cycle[idx]); end
      end
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL multi_done unexpected pulse at clock %0d", cyc); end
        else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || bus.opcode !== e.op || bus.cb_prefix !== e.cb) begin errors++;
            $display("FAIL multi_done got clock %0d op %h cb %b want clock %0d op %h cb %b", cyc, bus.opcode, bus.cb_prefix, e.cyc, e.op, e.cb); end
        end
      end
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL multi_missing_done pending %0d want 0", sb_q.size()); end
  endtask

  task automatic test_cond_fail();
    done_t e;
    schedule_t exp;
    control_t exp_ctrl;
    int exp_idx;
    do_reset();
    bus.mem_rdata = 8'h20;
    bus.cond_met  = 1'b0;
    exp = tb_decode(8'h20, 1'b0);
    sb_q.push_back('{15, 8'h20, 1'b0});
    sb_q.push_back('{19, 8'h80, 1'b0});
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 4) bus.mem_rdata = 8'h80;
      if (c >= 4 && c <= 15) begin
        exp_idx  = (c < 12) ? (c - 4) / 4 : 0;
        exp_ctrl = (c < 12) ? exp.cycle[exp_idx] : FETCH_CTRL;
        checks++;
        if (bus.m_idx !== 3'(exp_idx) || bus.ctrl !== exp_ctrl) begin errors++;
          $display("FAIL cond_step clock %0d got m_idx %0d ctrl %h want m_idx %0d ctrl %h", c, bus.m_idx, bus.ctrl, exp_idx, exp_ctrl); end
      end
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL cond_done unexpected pulse at clock %0d", cyc); end
        else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || bus.opcode !== e.op || bus.cb_prefix !== e.cb) begin errors++;
            $display("FAIL cond_done got clock %0d op %h cb %b want clock %0d op %h cb %b", cyc, bus.opcode, bus.cb_prefix, e.cyc, e.op, e.cb); end
        end
      end
    end
    bus.cond_met = 1'b1;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL cond_missing_done pending %0d want 0", sb_q.size()); end
  endtask

  task automatic test_cb_prefix();
    done_t e;
    do_reset();
    bus.mem_rdata = 8'hCB;
    sb_q.push_back('{7,  8'hCB, 1'b0});
    sb_q.push_back('{15, 8'h11, 1'b1});
    sb_q.push_back('{19, 8'h00, 1'b0});
    sb_q.push_back('{23, 8'hCB, 1'b0});
    sb_q.push_back('{31, 8'hCB, 1'b1});
    sb_q.push_back('{35, 8'h00, 1'b0});
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      case (c)
        4:  bus.mem_rdata = 8'h11;
        8:  bus.mem_rdata = 8'h00;
        16: bus.mem_rdata = 8'hCB;
        20: bus.mem_rdata = 8'hCB;
        24: bus.mem_rdata = 8'h00;
        default: ;
      endcase
      if (c == 8) begin checks++; if (bus.cb_prefix !== 1'b1 || bus.opcode !== 8'h11) begin errors++;
        $display("FAIL cb_t0 got op %h cb %b want op 11 cb 1", bus.opcode, bus.cb_prefix); end end
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL cb_done unexpected pulse at clock %0d", cyc); end
        else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || bus.opcode !== e.op || bus.cb_prefix !== e.cb) begin errors++;
            $display("FAIL cb_done got clock %0d op %h cb %b want clock %0d op %h cb %b", cyc, bus.opcode, bus.cb_prefix, e.cyc, e.op, e.cb); end
        end
      end
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL cb_missing_done pending %0d want 0", sb_q.size()); end
  endtask

  task automatic test_m_cycles_bounds();
    done_t e;
    do_reset();
    bus.mem_rdata = 8'h07;
    sb_q.push_back('{7,  8'h07, 1'b0});
    sb_q.push_back('{11, 8'h17, 1'b0});
    sb_q.push_back('{15, 8'h00, 1'b0});
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 4) bus.mem_rdata = 8'h17;
      if (c == 8) bus.mem_rdata = 8'h00;
      if (c >= 4) begin checks++; if (bus.m_idx !== 3'd0) begin errors++;
        $display("FAIL bounds_m_idx clock %0d got %0d want 0", c, bus.m_idx); end end
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL bounds_done unexpected pulse at clock %0d", cyc); end
        else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || bus.opcode !== e.op || bus.cb_prefix !== e.cb) begin errors++;
            $display("FAIL bounds_done got clock %0d op %h cb %b want clock %0d op %h cb %b", cyc, bus.opcode, bus.cb_prefix, e.cyc, e.op, e.cb); end
        end
      end
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bounds_missing_done pending %0d want 0", sb_q.size()); end
  endtask

  task automatic test_halt();
    done_t e;
    schedule_t nop_sched;
    logic exp_halted;
    control_t exp_ctrl;
    do_reset();
    bus.mem_rdata = 8'h76;
    nop_sched = tb_decode(8'h80, 1'b0);
    sb_q.push_back('{7, 8'h76, 1'b0});
`ifdef GB_CPU_SEQUENCER_HALT_EN
    sb_q.push_back('{31, 8'h80, 1'b0});
`else
    for (int k = 11; k <= 31; k += 4) sb_q.push_back('{k, 8'h80, 1'b0});
`endif
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 4)  bus.mem_rdata = 8'h80;
      if (c == 21) bus.irq_pending = 1'b1;
      if (c >= 8 && c <= 27) begin
`ifdef GB_CPU_SEQUENCER_HALT_EN
        exp_halted = (c <= 23);
        exp_ctrl   = (c <= 23) ? IDLE_CTRL : FETCH_CTRL;
`else
        exp_halted = 1'b0;
        exp_ctrl   = nop_sched.cycle[0];
`endif
        checks++;
        if (bus.halted !== exp_halted || bus.ctrl !== exp_ctrl) begin errors++;
          $display("FAIL halt_step clock %0d got halted %b ctrl %h want halted %b ctrl %h", c, bus.halted, bus.ctrl, exp_halted, exp_ctrl); end
      end
      if (bus.instr_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL halt_done unexpected pulse at clock %0d", cyc); end
        else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || bus.opcode !== e.op || bus.cb_prefix !== e.cb) begin errors++;
            $display("FAIL halt_done got clock %0d op %h cb %b want clock %0d op %h cb %b", cyc, bus.opcode, bus.cb_prefix, e.cyc, e.op, e.cb); end
        end
      end
    end
    bus.irq_pending = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL halt_missing_done pending %0d want 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mem_rdata = 8'h08;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 4) bus.mem_rdata = 8'h00;
      if (bus.instr_done === 1'b1) begin
        checks++; errors++;
        $display("FAIL rmid_done unexpected pulse at clock %0d want none", cyc);
      end
    end
    checks++; if (bus.m_idx !== 3'd4 || bus.t_phase !== 2'd2) begin errors++;
      $display("FAIL rmid_position got m_idx %0d t_phase %0d want m_idx 4 t_phase 2", bus.m_idx, bus.t_phase); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.t_phase !== 2'd0) begin errors++; $display("FAIL rmid_t_phase got %0d want 0", bus.t_phase); end
    checks++; if (bus.m_idx !== 3'd0) begin errors++; $display("FAIL rmid_m_idx got %0d want 0", bus.m_idx); end
    checks++; if (bus.opcode !== 8'h00) begin errors++; $display("FAIL rmid_opcode got %h want 00", bus.opcode); end
    checks++; if (bus.cb_prefix !== 1'b0) begin errors++; $display("FAIL rmid_cb_prefix got %b want 0", bus.cb_prefix); end
    checks++; if (bus.instr_done !== 1'b0) begin errors++; $display("FAIL rmid_instr_done got %b want 0", bus.instr_done); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rmid_halted got %b want 0", bus.halted); end
    checks++; if (bus.ctrl !== FETCH_CTRL) begin errors++; $display("FAIL rmid_ctrl got %h want %h", bus.ctrl, FETCH_CTRL); end
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.mem_rdata   = 8'h00;
    bus.cond_met    = 1'b1;
    bus.irq_pending = 1'b0;
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_cond_fail();
    test_cb_prefix();
    test_m_cycles_bounds();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
